// File: rtl/icache_pkg.sv
// ============================================================================
// Module   : icache_pkg
// Brief    : Shared I-cache refill constants and line-fill state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package icache_pkg;

    localparam int WORD_WIDTH   = 20;
    localparam int NUM_WORDS    = 16;
    localparam int OFFSET_WIDTH = 4;
    localparam int LINE_WIDTH   = WORD_WIDTH * NUM_WORDS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/line_fill_assembler.sv
// ============================================================================
// Module   : line_fill_assembler
// Brief    : Packs a critical-word-first wrapped refill stream into one cache
//            line, forwards the critical word, hands the line off via valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module line_fill_assembler #(
    parameter int WORD_WIDTH   = icache_pkg::WORD_WIDTH,
    parameter int NUM_WORDS    = icache_pkg::NUM_WORDS,
    parameter int OFFSET_WIDTH = icache_pkg::OFFSET_WIDTH
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_req_valid,
    input  logic [OFFSET_WIDTH-1:0]           i_req_offset,
    output logic                              o_req_ready,
    input  logic [WORD_WIDTH-1:0]             i_word,
    input  logic                              i_word_valid,
    output logic                              o_word_ready,
    output logic [WORD_WIDTH-1:0]             o_crit_word,
    output logic                              o_crit_valid,
    output logic [WORD_WIDTH*NUM_WORDS-1:0]   o_line_data,
    output logic                              o_line_valid,
    input  logic                              i_line_ready,
    output logic                              o_busy
);

    import icache_pkg::*;

    localparam int LINE_W = WORD_WIDTH * NUM_WORDS;

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [OFFSET_WIDTH-1:0] r_ptr;
    logic [OFFSET_WIDTH-1:0] r_cnt;
    logic [LINE_W-1:0]       r_line;
    logic [WORD_WIDTH-1:0]   r_crit_word;
    logic                    r_crit_valid;
    logic                    w_req_fire;
    logic                    w_beat_fire;
    logic                    w_last_beat;

    assign w_req_fire  = i_req_valid & o_req_ready;
    assign w_beat_fire = i_word_valid & o_word_ready;
    assign w_last_beat = (r_cnt == OFFSET_WIDTH'(NUM_WORDS - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_fire)                 w_state_next = ST_FILL;
            ST_FILL: if (w_beat_fire && w_last_beat) w_state_next = ST_DONE;
            ST_DONE: if (i_line_ready)               w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready  = (r_state == ST_IDLE);
        o_word_ready = (r_state == ST_FILL);
        o_line_valid = (r_state == ST_DONE);
        o_busy       = (r_state == ST_FILL) || (r_state == ST_DONE);
    end

    // The line is cleared when a request is accepted, so slots never show
    // data left over from the previous fill.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_line       <= '0;
            r_crit_word  <= '0;
            r_crit_valid <= 1'b0;
        end else begin
            r_crit_valid <= 1'b0;
            if (w_req_fire) begin
                r_ptr  <= i_req_offset;
                r_cnt  <= '0;
                r_line <= '0;
            end
            if (w_beat_fire) begin
                r_line[r_ptr*WORD_WIDTH +: WORD_WIDTH] <= i_word;
                r_ptr <= r_ptr + OFFSET_WIDTH'(1);
                r_cnt <= r_cnt + OFFSET_WIDTH'(1);
                if (r_cnt == '0) begin
                    r_crit_word  <= i_word;
                    r_crit_valid <= 1'b1;
                end
            end
        end
    end

    assign o_crit_word  = r_crit_word;
    assign o_crit_valid = r_crit_valid;
    assign o_line_data  = r_line;

endmodule

`default_nettype wire

// File: doc/line_fill_assembler.md
Name: line_fill_assembler

Overview:
- Write-side counterpart of the I-cache miss path: packs a memory refill stream of 20-bit words, sent critical-word-first with wrap, into one 320-bit cache line.
- Returns the critical (missed) word as soon as it arrives.
- Presents the completed line to the data/tag array write logic through a valid/ready handshake.
- Sits between the memory interface and the cache line write port.

Parameters:
- WORD_WIDTH, 20, bits per instruction word.
- NUM_WORDS, 16, words per cache line.
- OFFSET_WIDTH, 4, block offset width (log2 NUM_WORDS).
- LINE_WIDTH, 320, WORD_WIDTH*NUM_WORDS. Derived localparam, not overridable.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_req_valid  input  1  new fill request.
- i_req_offset  input  OFFSET_WIDTH  block offset of the missed word (first beat's slot).
- o_req_ready  output  1  request accepted when high with i_req_valid.
- i_word  input  WORD_WIDTH  refill beat data.
- i_word_valid  input  1  beat present.
- o_word_ready  output  1  beat accepted when high with i_word_valid.
- o_crit_word  output  WORD_WIDTH  critical word.
- o_crit_valid  output  1  one-cycle pulse qualifying o_crit_word.
- o_line_data  output  LINE_WIDTH  assembled line; slot k occupies bits [k*20+19 : k*20].
- o_line_valid  output  1  line complete.
- i_line_ready  input  1  consumer takes the line.
- o_busy  output  1  high in FILL or DONE.

Behaviour:
- Reset (i_reset=1 at an edge), values next cycle:
  - state=IDLE.
  - o_line_data=0, o_line_valid=0, o_crit_valid=0, o_crit_word=0.
  - Slot pointer and beat counter = 0.
  - o_busy=0, o_word_ready=0, o_req_ready=1.
- Reset mid-fill or in DONE: partial or complete line is discarded, no output pulse, back to IDLE.
- Handshake readiness (combinational from state):
  - o_req_ready = (state==IDLE).
  - o_word_ready = (state==FILL).
  - o_line_valid = (state==DONE).
- IDLE:
  - On i_req_valid & o_req_ready: latch ptr=i_req_offset, cnt=0, clear o_line_data to 0, go to FILL.
  - i_word_valid in IDLE is ignored; no beat is accepted.
- FILL:
  - Each accepted beat writes i_word into slot ptr.
  - Then ptr=ptr+1 mod 16 (15 wraps to 0) and cnt=cnt+1.
  - Gaps (i_word_valid=0) hold all state.
  - Beat with cnt==0: o_crit_word<=i_word and o_crit_valid=1 for exactly the following cycle.
  - Beat with cnt==15: go to DONE.
- DONE:
  - o_line_data held stable; no new request or beat accepted.
  - On i_line_ready: go to IDLE next cycle.
  - o_line_data keeps its value until the next request clears it.
- Latency, with request accepted at edge T and back-to-back beats:
  - First beat accepted at T+1; o_crit_valid high in cycle T+2.
  - 16th beat at T+16; o_line_valid high from T+17.
  - IDLE again the cycle after the i_line_ready handshake.
- Invariant: slot i_req_offset of o_line_data equals o_crit_word once DONE.
- Exactly 16 beats per request; beats are always delivered in wrap order.
- No pipelining of a second request during FILL or DONE.
- State encoding: IDLE=2'd0, FILL=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.

Decomposition:
- Shared package icache_pkg holds:
  - WORD_WIDTH, NUM_WORDS, OFFSET_WIDTH, LINE_WIDTH constants.
  - Fill-state encoding constants.
- Slot write uses an indexed part-select (ptr*WORD_WIDTH +: WORD_WIDTH).
- No sub-module needed; single module of roughly 150-200 lines.

Test Plan:
- Offset 0, beats 20'h00000..20'h0000F back-to-back:
  - o_crit_word=20'h00000 pulse at T+2.
  - o_line_valid at T+17 with line[19:0]=0 and line[319:300]=20'h0000F.
- Offset 13, beats 20'hA0000+n (n=0..15):
  - Slot 13=A0000, 14=A0001, 15=A0002, 0=A0003, 12=A000F.
  - o_crit_word=A0000.
- Offset 15, beats with random gaps on i_word_valid:
  - Line contents match the gap-free run.
  - o_crit_valid exactly one pulse; line valid one cycle after 16th accepted beat.
- Hold i_line_ready=0 for 5 cycles in DONE while driving i_req_valid=1 and i_word_valid=1:
  - o_line_data stable; o_req_ready=0, o_word_ready=0.
  - Release gives IDLE next cycle.
- Assert i_reset after 7 beats of an offset-4 fill:
  - Next cycle: o_busy=0, o_line_data=0.
  - o_line_valid never asserts for that fill.
  - New offset-2 fill produces a clean line.
- i_word_valid=1 in IDLE with no request:
  - o_word_ready=0, no state change, o_crit_valid stays 0.
